// File: rtl/multi_debouncer.sv
// N-channel push-button conditioner: synchroniser, tick-sampled stability filter,
// registered level, one-cycle press/release pulses and hold-to-auto-repeat pulses.
module multi_debouncer #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_CNT   = 3,
  parameter int unsigned REPEAT_DELAY = 100,
  parameter int unsigned REPEAT_RATE  = 20
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] btn_level_o,
  output logic [N_CH-1:0] btn_rise_o,
  output logic [N_CH-1:0] btn_fall_o,
  output logic [N_CH-1:0] btn_repeat_o,
  output logic            tick_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CntMax = CW'(STABLE_CNT - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] samp;
  logic [PW-1:0]   pre_q, pre_d;
  logic            strobe;
  logic [N_CH-1:0] level_q, level_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] rise_q, fall_q;

  assign samp = sync_q[SYNC_STAGES-1];

  // The synchroniser keeps running while en_i is low so resuming sees fresh data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= btn_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign strobe = en_i && (pre_q == PreMax);
  assign tick_o = strobe && !rst_i;

  always_comb begin
    pre_d = pre_q;
    if (en_i) pre_d = strobe ? '0 : pre_q + 1'b1;
  end

  always_comb begin
    level_d = level_q;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (strobe) begin
        if (samp[ch] == level_q[ch]) begin
          cnt_d[ch] = '0;
        end else if (cnt_q[ch] < CntMax) begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end else begin
          level_d[ch] = samp[ch];
          cnt_d[ch]   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) cnt_q[ch] <= '0;
    end else begin
      pre_q   <= pre_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
      for (int unsigned ch = 0; ch < N_CH; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  assign btn_level_o = level_q;
  assign btn_rise_o  = rise_q;
  assign btn_fall_o  = fall_q;

  if (REPEAT_DELAY > 0) begin : g_rep
    localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
    localparam logic [HW-1:0] DelayVal  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] ReloadVal = HW'(REPEAT_DELAY - REPEAT_RATE);

    logic [HW-1:0]   hold_q [N_CH];
    logic [HW-1:0]   hold_d [N_CH];
    logic [N_CH-1:0] rep_q, rep_d;

    // Clearing on !level_q covers the rise cycle; clearing on !level_d suppresses
    // a repeat pulse in the same cycle as the release.
    always_comb begin
      rep_d = '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        hold_d[ch] = hold_q[ch];
        if (!level_q[ch] || !level_d[ch]) begin
          hold_d[ch] = '0;
        end else if (strobe) begin
          if (hold_q[ch] + 1'b1 == DelayVal) begin
            rep_d[ch]  = 1'b1;
            hold_d[ch] = ReloadVal;
          end else begin
            hold_d[ch] = hold_q[ch] + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rep_q <= '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) hold_q[ch] <= '0;
      end else begin
        rep_q <= rep_d;
        for (int unsigned ch = 0; ch < N_CH; ch++) hold_q[ch] <= hold_d[ch];
      end
    end

    assign btn_repeat_o = rep_q;
  end else begin : g_norep
    assign btn_repeat_o = '0;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed vector table, corner-case sequences and
// randomized stimulus against a tick/run-length reference model (two prescaler settings).
module tb_multi_debouncer;

  localparam int Sync   = 2;
  localparam int Stable = 3;
  localparam int Delay  = 10;
  localparam int Rate   = 4;
  localparam int NCh    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en;
  logic [3:0]      btn;
  logic [1:0][3:0] o_lvl, o_rise, o_fall, o_rep;
  logic [1:0]      o_tick;

  multi_debouncer #(
    .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_CNT(3),
    .REPEAT_DELAY(10), .REPEAT_RATE(4)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .btn_i(btn),
    .btn_level_o(o_lvl[0]), .btn_rise_o(o_rise[0]), .btn_fall_o(o_fall[0]),
    .btn_repeat_o(o_rep[0]), .tick_o(o_tick[0])
  );

  multi_debouncer #(
    .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_CNT(3),
    .REPEAT_DELAY(10), .REPEAT_RATE(4)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .btn_i(btn),
    .btn_level_o(o_lvl[1]), .btn_rise_o(o_rise[1]), .btn_fall_o(o_fall[1]),
    .btn_repeat_o(o_rep[1]), .tick_o(o_tick[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: delay line for the synchroniser, enabled-cycle count for ticks,
  // run length of disagreeing samples for the filter, ticks-held for repeats.
  int         tdiv [2] = '{1, 4};
  logic [3:0] pipe [Sync];
  logic [3:0] m_lvl [2], m_rise [2], m_fall [2], m_rep [2];
  int         m_dis [2][NCh];
  int         m_held [2][NCh];
  int         m_ecnt [2];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] s, old;
    bit tk;
    if (rst) begin
      for (int i = 0; i < Sync; i++) pipe[i] = '0;
      for (int d = 0; d < 2; d++) begin
        m_lvl[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_rep[d] = '0; m_ecnt[d] = 0;
        for (int c = 0; c < NCh; c++) begin m_dis[d][c] = 0; m_held[d][c] = 0; end
      end
    end else begin
      s = pipe[0];
      for (int i = 0; i < Sync - 1; i++) pipe[i] = pipe[i+1];
      pipe[Sync-1] = btn;
      for (int d = 0; d < 2; d++) begin
        tk = en && ((m_ecnt[d] % tdiv[d]) == tdiv[d] - 1);
        if (en) m_ecnt[d]++;
        old = m_lvl[d];
        m_rep[d] = '0;
        for (int c = 0; c < NCh; c++) begin
          if (tk) begin
            if (s[c] == old[c]) m_dis[d][c] = 0;
            else begin
              m_dis[d][c]++;
              if (m_dis[d][c] == Stable) begin m_lvl[d][c] = s[c]; m_dis[d][c] = 0; end
            end
          end
          if (!old[c] || !m_lvl[d][c]) m_held[d][c] = 0;
          else if (tk) begin
            m_held[d][c]++;
            if (m_held[d][c] >= Delay && ((m_held[d][c] - Delay) % Rate) == 0)
              m_rep[d][c] = 1'b1;
          end
        end
        m_rise[d] = m_lvl[d] & ~old;
        m_fall[d] = ~m_lvl[d] & old;
      end
    end
  endtask

  task automatic compare_all();
    logic et;
    for (int d = 0; d < 2; d++) begin
      et = en && !rst && ((m_ecnt[d] % tdiv[d]) == tdiv[d] - 1);
      chk($sformatf("model_level[%0d]", d), {4'b0, o_lvl[d]},  {4'b0, m_lvl[d]});
      chk($sformatf("model_rise[%0d]", d),  {4'b0, o_rise[d]}, {4'b0, m_rise[d]});
      chk($sformatf("model_fall[%0d]", d),  {4'b0, o_fall[d]}, {4'b0, m_fall[d]});
      chk($sformatf("model_repeat[%0d]", d), {4'b0, o_rep[d]}, {4'b0, m_rep[d]});
      chk($sformatf("model_tick[%0d]", d),  {7'b0, o_tick[d]}, {7'b0, et});
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] b);
    rst = r; en = e; btn = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic [3:0] b,
                     input logic [3:0] l, input logic [3:0] ri, input logic [3:0] f);
    vec_t v;
    v.rst = r; v.en = 1'b1; v.btn = b; v.lvl = l; v.rise = ri; v.fall = f;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt_r, cnt_f, ticks, r_step, late, bad;
    int offs[$];
    logic found;
    logic [15:0] pat;
    logic [3:0] b;
    rst = 1'b1; en = 1'b1; btn = '0;

    // Reset, power-up qualification, release, then glitch reject and minimal press on ch0.
    add(3, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    add(4, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0);
    add(1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0);
    add(4, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0);
    add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(2, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(3, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 1'b0, 4'h0, 4'h1, 4'h1, 4'h0);
    add(2, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0);
    add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1);
    add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].btn);
      chk($sformatf("tbl%0d_level", i), {4'b0, o_lvl[0]},  {4'b0, tbl[i].lvl});
      chk($sformatf("tbl%0d_rise", i),  {4'b0, o_rise[0]}, {4'b0, tbl[i].rise});
      chk($sformatf("tbl%0d_fall", i),  {4'b0, o_fall[0]}, {4'b0, tbl[i].fall});
    end

    // Bounce on ch1: press then release, each must give a single edge pulse.
    pat = 16'b0000_0000_1110_1101;
    cnt_r = 0; cnt_f = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, (i < 8) ? {2'b0, pat[i], 1'b0} : 4'b0010);
      cnt_r += int'(o_rise[0][1]); cnt_f += int'(o_fall[0][1]);
    end
    chk("bounce_press_rises", 8'(cnt_r), 8'd1);
    chk("bounce_press_falls", 8'(cnt_f), 8'd0);
    pat = 16'b0000_0000_0001_0010;
    cnt_r = 0; cnt_f = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, (i < 8) ? {2'b0, pat[i], 1'b0} : 4'b0000);
      cnt_r += int'(o_rise[0][1]); cnt_f += int'(o_fall[0][1]);
    end
    chk("bounce_release_falls", 8'(cnt_f), 8'd1);
    chk("bounce_release_rises", 8'(cnt_r), 8'd0);

    // Auto-repeat on ch2: held 40 cycles, pulses at 10,14,18,... ticks after the rise.
    r_step = -1; late = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, (i < 40) ? 4'b0100 : 4'b0000);
      if (o_rise[0][2]) r_step = i;
      if (o_rep[0][2]) begin
        if (i < 44) offs.push_back(i - r_step);
        else late++;
      end
    end
    chk("repeat_rise_step", 8'(r_step), 8'd4);
    chk("repeat_pulse_count", 8'(offs.size()), 8'd8);
    foreach (offs[j]) chk($sformatf("repeat_offset%0d", j), 8'(offs[j]), 8'(10 + 4 * j));
    chk("repeat_after_release", 8'(late), 8'd0);

    // Prescaler: fresh reset, then one tick every 4th cycle on the TICK_DIV=4 instance.
    step(1'b1, 1'b1, 4'h0);
    step(1'b1, 1'b1, 4'h0);
    ticks = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 4'h0);
      ticks += int'(o_tick[1]); n += int'(o_tick[0]);
    end
    chk("presc_div4_ticks", 8'(ticks), 8'd10);
    chk("presc_div1_ticks", 8'(n), 8'd40);
    ticks = 0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      ticks += int'(o_tick[1]);
      step(1'b0, 1'b1, 4'b1000);
      found = o_rise[1][3];
    end
    chk("presc_press_found", {7'b0, found}, 8'd1);
    chk("presc_press_ticks", {7'b0, (ticks >= 3 && ticks <= 4)}, 8'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'h0);

    // en freeze while held, then reset mid-press and re-qualification.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b1, 4'b1000);
      found = o_lvl[0][3];
    end
    chk("hold_level_up", {7'b0, found}, 8'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 4'b1000);
      if ((o_rise | o_fall | o_rep) != '0 || o_tick != '0 || !o_lvl[0][3]) bad++;
    end
    chk("en_freeze_quiet", 8'(bad), 8'd0);
    cnt_r = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'b1000);
      cnt_r += int'(o_rise[0][3]);
    end
    chk("en_resume_no_rise", 8'(cnt_r), 8'd0);
    step(1'b1, 1'b1, 4'b1000);
    chk("rst_mid_level", {4'b0, o_lvl[0]}, 8'h0);
    chk("rst_mid_fall", {4'b0, o_fall[0]}, 8'h0);
    n = 0; found = 1'b0;
    for (int i = 1; i <= 12 && !found; i++) begin
      step(1'b0, 1'b1, 4'b1000);
      if (o_rise[0][3]) begin found = 1'b1; n = i; end
    end
    chk("requalify_edges", 8'(n), 8'(Sync + Stable));

    // Randomized stimulus against the model, with varying bounce density.
    b = '0;
    for (int ph = 0; ph < 4; ph++) begin
      int flip_div;
      flip_div = (ph == 0) ? 2 : (ph == 1) ? 6 : (ph == 2) ? 20 : 4;
      for (int i = 0; i < 500; i++) begin
        for (int c = 0; c < NCh; c++)
          if ($urandom_range(0, flip_div - 1) == 0) b[c] = ~b[c];
        step($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0, b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
